inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have parameter PC_STEP, default 4, address increment per fetched instruction.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port fetch_en  input  1  permits new fetches when high.
REQ-007 SHALL have port inst_addr  output  32  instruction memory address; equals the internal fetch PC.
REQ-008 SHALL have port instruction  input  32  instruction memory read data, combinational from inst_addr in the same cycle.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump redirect request from the core.
REQ-010 SHALL have port redirect_pc  input  32  target address of the redirect.
REQ-011 SHALL have port inst_valid  output  1  queue head holds a valid instruction.
REQ-012 SHALL have port inst_out  output  32  instruction at queue head.
REQ-013 SHALL have port inst_pc  output  32  address the head instruction was fetched from.
REQ-014 SHALL have port inst_ready  input  1  core accepts the head this cycle.
REQ-015 SHALL have port occupancy  output  $clog2(DEPTH)+1  number of valid entries.
REQ-016 SHALL have port stall_cnt  output  32  empty-queue cycle counter (see Configuration).

Function
REQ-017 Pop SHALL occur in a cycle where inst_valid=1 and inst_ready=1; head advances next edge.
REQ-018 Push SHALL occur when fetch_en=1, redirect_valid=0, and (occupancy<DEPTH or pop this cycle); stores {instruction, inst_addr} at tail, fetch PC += PC_STEP.
REQ-019 Without push, fetch PC SHALL hold its value.
REQ-020 Fetch-to-visible latency SHALL be 1 cycle: instruction pushed at edge N appears with inst_valid=1 after edge N if queue was empty.
REQ-021 Full queue with simultaneous pop SHALL push in the same cycle; occupancy unchanged.
REQ-022 Full queue without pop SHALL NOT push; inst_addr holds.
REQ-023 Empty queue: inst_valid=0; inst_ready ignored; occupancy never underflows.
REQ-024 redirect_valid=1 SHALL take precedence: pop in that cycle is honoured, all entries discarded, no push, fetch PC <= redirect_pc at the edge; occupancy=0 next cycle.
REQ-025 inst_out/inst_pc while inst_valid=0 SHALL be 0.
REQ-026 Fetch PC SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 -> 0).
REQ-027 Head/tail pointers SHALL wrap modulo DEPTH; entries delivered strictly in fetch order.

Reset
REQ-028 With rst=1 at an edge: fetch PC <= RESET_PC, occupancy <= 0, pointers <= 0, stall_cnt <= 0.
REQ-029 During and after reset until first push: inst_addr=RESET_PC, inst_valid=0, inst_out=0, inst_pc=0.
REQ-030 rst SHALL override redirect_valid, fetch_en and inst_ready in the same cycle; reset mid-stream discards queued entries.

Configuration
REQ-031 Macro FETCH_STATS_EN defined: stall_cnt increments each cycle with rst=0 and inst_valid=0, saturates at 32'hFFFF_FFFF.
REQ-032 FETCH_STATS_EN undefined: stall_cnt SHALL be constant 0, no counter logic; all other behaviour identical.

Verification
REQ-033 Reset, fetch_en=1, inst_ready=1, memory Mem[k]=k: inst_addr 0,4,8,...; inst_pc trails inst_addr by one cycle; inst_valid=1 from second cycle after reset.
REQ-034 inst_ready=0, fetch_en=1 for 10 cycles: occupancy 1,2,3,4,4...; inst_addr stops at 16; then inst_ready=1 streams pcs 0,4,8,12,16 in order.
REQ-035 Queue full (4), redirect_valid=1 with redirect_pc=0x100 and inst_ready=1: next cycle occupancy=0, inst_valid=0, inst_addr=0x100; following cycle inst_pc=0x100.
REQ-036 RESET_PC=32'hFFFF_FFF8, run 4 fetches: inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0, 4.
REQ-037 Assert rst with occupancy=3: next cycle occupancy=0, inst_addr=RESET_PC, inst_valid=0.
REQ-038 FETCH_STATS_EN defined, fetch_en=0 for 20 cycles after reset: stall_cnt=20; undefined: stall_cnt=0.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit with an in-order DEPTH-entry fetch queue and branch redirect.
// Optional empty-queue stall counter is enabled with the FETCH_STATS_EN macro.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_en,
  output logic [31:0]              inst_addr,
  input  logic [31:0]              instruction,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     inst_valid,
  output logic [31:0]              inst_out,
  output logic [31:0]              inst_pc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [31:0]              stall_cnt
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   inst_mem_d [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   pc_mem_d   [DEPTH];
  logic          valid;
  logic          pop;
  logic          push;

  assign valid = (count_q != '0);
  assign pop   = valid && inst_ready;
  // A full queue may still accept a fetch when the head leaves in the same cycle.
  assign push  = fetch_en && !redirect_valid && ((count_q != FULL_CNT) || pop);

  always_comb begin
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        inst_mem_d[tail_q] = instruction;
        pc_mem_d[tail_q]   = pc_q;
        tail_d             = tail_q + PTR_ONE;
        pc_d               = pc_q + PC_STEP;
      end
      if (pop) begin
        head_d = head_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    inst_mem_q <= inst_mem_d;
    pc_mem_q   <= pc_mem_d;
  end

  assign inst_addr  = pc_q;
  assign inst_valid = valid;
  assign inst_out   = valid ? inst_mem_q[head_q] : '0;
  assign inst_pc    = valid ? pc_mem_q[head_q] : '0;
  assign occupancy  = count_q;

`ifdef FETCH_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!valid && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue: a default-parameter instance
// plus a second instance with RESET_PC near the top of the address space.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_ready = 1'b0;

  logic [31:0] inst_addr, instruction, inst_out, inst_pc, stall_cnt;
  logic        inst_valid;
  logic [2:0]  occupancy;

  logic [31:0] b_inst_addr, b_instruction, b_inst_out, b_inst_pc, b_stall_cnt;
  logic        b_inst_valid;
  logic [2:0]  b_occupancy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instruction memory: Mem[k] = k with k the word index.
  assign instruction   = inst_addr >> 2;
  assign b_instruction = b_inst_addr >> 2;

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .inst_addr(inst_addr),
    .instruction(instruction), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(32'd4)) dut_wrap (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .inst_addr(b_inst_addr),
    .instruction(b_instruction), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(b_inst_valid), .inst_out(b_inst_out), .inst_pc(b_inst_pc),
    .inst_ready(inst_ready), .occupancy(b_occupancy), .stall_cnt(b_stall_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    fetch_en = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    tick();
    tick();
    checks++; if (inst_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=%h", inst_addr, 32'h0); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
    checks++; if (inst_out !== 32'h0) begin failures++; $display("FAIL reset_out got=%h exp=0", inst_out); end
    checks++; if (inst_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", inst_pc); end
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if (stall_cnt !== 32'h0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    checks++; if (b_inst_addr !== 32'hFFFF_FFF8) begin failures++; $display("FAIL reset_addr_b got=%h exp=fffffff8", b_inst_addr); end
    rst = 1'b0;
  endtask

  task automatic test_stall;
    logic [31:0] exp_stall;
    fetch_en = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
`ifdef FETCH_STATS_EN
    exp_stall = 32'd20;
`else
    exp_stall = 32'd0;
`endif
    checks++; if (stall_cnt !== exp_stall) begin failures++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL stall_occ got=%0d exp=0", occupancy); end
    checks++; if (inst_addr !== 32'h0) begin failures++; $display("FAIL stall_addr got=%h exp=0", inst_addr); end
  endtask

  task automatic test_stream;
    logic [31:0] e_addr, e_pc, e_out;
    do_reset();
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL stream_valid0 got=%b exp=0", inst_valid); end
    for (int k = 1; k <= 6; k++) begin
      tick();
      e_addr = 32'(4 * k);
      e_pc   = 32'(4 * (k - 1));
      e_out  = 32'(k - 1);
      checks++; if (inst_addr !== e_addr) begin failures++; $display("FAIL stream_addr[%0d] got=%h exp=%h", k, inst_addr, e_addr); end
      checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%b exp=1", k, inst_valid); end
      checks++; if (inst_pc !== e_pc) begin failures++; $display("FAIL stream_pc[%0d] got=%h exp=%h", k, inst_pc, e_pc); end
      checks++; if (inst_out !== e_out) begin failures++; $display("FAIL stream_out[%0d] got=%h exp=%h", k, inst_out, e_out); end
      checks++; if (occupancy !== 3'd1) begin failures++; $display("FAIL stream_occ[%0d] got=%0d exp=1", k, occupancy); end
    end
  endtask

  task automatic test_fill_drain;
    int n;
    logic [2:0]  e_occ;
    logic [31:0] e_addr, e_pc;
    do_reset();
    fetch_en = 1'b1;
    inst_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n = (i < 4) ? i : 4;
      e_occ  = 3'(n);
      e_addr = 32'(4 * n);
      checks++; if (occupancy !== e_occ) begin failures++; $display("FAIL fill_occ[%0d] got=%0d exp=%0d", i, occupancy, e_occ); end
      checks++; if (inst_addr !== e_addr) begin failures++; $display("FAIL fill_addr[%0d] got=%h exp=%h", i, inst_addr, e_addr); end
    end
    checks++; if (inst_pc !== 32'h0) begin failures++; $display("FAIL fill_head got=%h exp=0", inst_pc); end
    inst_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      tick();
      e_pc = 32'(4 * j);
      checks++; if (inst_pc !== e_pc) begin failures++; $display("FAIL drain_pc[%0d] got=%h exp=%h", j, inst_pc, e_pc); end
      checks++; if (inst_out !== 32'(j)) begin failures++; $display("FAIL drain_out[%0d] got=%h exp=%h", j, inst_out, 32'(j)); end
      checks++; if (occupancy !== 3'd4) begin failures++; $display("FAIL drain_occ[%0d] got=%0d exp=4", j, occupancy); end
    end
  endtask

  task automatic test_redirect;
    do_reset();
    fetch_en = 1'b1;
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (occupancy !== 3'd4) begin failures++; $display("FAIL redir_full got=%0d exp=4", occupancy); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    inst_ready = 1'b1;
    tick();
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL redir_occ got=%0d exp=0", occupancy); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL redir_valid got=%b exp=0", inst_valid); end
    checks++; if (inst_addr !== 32'h100) begin failures++; $display("FAIL redir_addr got=%h exp=100", inst_addr); end
    checks++; if (inst_out !== 32'h0) begin failures++; $display("FAIL redir_out got=%h exp=0", inst_out); end
    redirect_valid = 1'b0;
    tick();
    checks++; if (inst_pc !== 32'h100) begin failures++; $display("FAIL redir_pc got=%h exp=100", inst_pc); end
    checks++; if (inst_out !== 32'h40) begin failures++; $display("FAIL redir_inst got=%h exp=40", inst_out); end
    checks++; if (inst_addr !== 32'h104) begin failures++; $display("FAIL redir_next got=%h exp=104", inst_addr); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    fetch_en = 1'b1;
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (occupancy !== 3'd3) begin failures++; $display("FAIL rstmid_pre got=%0d exp=3", occupancy); end
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    inst_ready = 1'b1;
    tick();
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL rstmid_occ got=%0d exp=0", occupancy); end
    checks++; if (inst_addr !== 32'h0) begin failures++; $display("FAIL rstmid_addr got=%h exp=0", inst_addr); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", inst_valid); end
    rst = 1'b0;
    redirect_valid = 1'b0;
    tick();
    checks++; if (inst_pc !== 32'h0 || inst_valid !== 1'b1) begin failures++; $display("FAIL rstmid_restart got=%h/%b exp=0/1", inst_pc, inst_valid); end
  endtask

  task automatic test_pc_wrap;
    logic [31:0] e_pc;
    do_reset();
    fetch_en = 1'b1;
    inst_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      e_pc = 32'hFFFF_FFF8 + 32'(4 * (k - 1));
      checks++; if (b_inst_pc !== e_pc) begin failures++; $display("FAIL wrap_pc[%0d] got=%h exp=%h", k, b_inst_pc, e_pc); end
    end
    checks++; if (b_inst_addr !== 32'h8) begin failures++; $display("FAIL wrap_addr got=%h exp=8", b_inst_addr); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_stream();
    test_fill_drain();
    test_redirect();
    test_reset_mid();
    test_pc_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
